// File: rtl/uart_rx_core.sv
// uart_rx_core: byte-level UART receiver, 8N1, LSB first, idle-high line.
// Recovers one byte per frame and presents it with a level rdy flag.
//
// Optional build macro: UART_RX_PARITY_EN
//   defined   -> 8E1 framing with a PARITY state; par_err reports mismatch
//   undefined -> 8N1 framing; par_err tied to 0
//
// Ports:
//   clk      system clock, all logic on posedge
//   rst      synchronous active-high reset
//   RX       serial line, asynchronous to clk, idle high
//   clr_rdy  single-cycle pulse that clears rdy
//   rx_data  last completed byte, held until the next frame completes
//   rdy      a byte is available in rx_data
//   frm_err  stop bit of the last frame sampled low
//   par_err  parity mismatch on the last frame (0 when parity disabled)

module uart_rx_core #(
   parameter int unsigned BAUD_DIV = 2604
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       RX,
   input  logic       clr_rdy,
   output logic [7:0] rx_data,
   output logic       rdy,
   output logic       frm_err,
   output logic       par_err
);

   localparam int unsigned CNT_W = $clog2(BAUD_DIV + 1);
   localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t           state;
   logic             rx_sync1;
   logic             rx_sync2;
   logic             rx_prev;
   logic [CNT_W-1:0] baud_cnt;
   logic [3:0]       bit_cnt;
   logic [7:0]       shift_reg;
   logic             sample_c;
`ifdef UART_RX_PARITY_EN
   logic             par_bit;
`endif

   // Mid-bit sample point
   assign sample_c = (baud_cnt == '0);

`ifndef UART_RX_PARITY_EN
   assign par_err = 1'b0;
`endif

   // Synchronizer, frame state machine and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rx_sync1  <= 1'b1;
         rx_sync2  <= 1'b1;
         rx_prev   <= 1'b1;
         baud_cnt  <= '0;
         bit_cnt   <= 4'd0;
         shift_reg <= 8'h00;
         rx_data   <= 8'h00;
         rdy       <= 1'b0;
         frm_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit   <= 1'b0;
         par_err   <= 1'b0;
`endif
      end else begin
         rx_sync1 <= RX;
         rx_sync2 <= rx_sync1;
         rx_prev  <= rx_sync2;

         // Placed first so a same-cycle set in STOP takes priority
         if (clr_rdy) rdy <= 1'b0;

         case (state)
            IDLE: begin
               // Only a falling edge arms; a stuck-low line is ignored
               if (!rx_sync2 && rx_prev) begin
                  state    <= START;
                  baud_cnt <= HALF_LOAD;
                  rdy      <= 1'b0;
               end
            end

            START: begin
               if (sample_c) begin
                  if (!rx_sync2) begin
                     state    <= DATA;
                     baud_cnt <= FULL_LOAD;
                     bit_cnt  <= 4'd0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end

            DATA: begin
               if (sample_c) begin
                  shift_reg <= {rx_sync2, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 4'd1;
                  baud_cnt  <= FULL_LOAD;
                  if (bit_cnt == 4'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (sample_c) begin
                  par_bit  <= rx_sync2;
                  baud_cnt <= FULL_LOAD;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end
`endif

            STOP: begin
               // Leaving at mid-stop-bit lets a back-to-back start be caught
               if (sample_c) begin
                  rx_data <= shift_reg;
                  rdy     <= 1'b1;
                  frm_err <= ~rx_sync2;
`ifdef UART_RX_PARITY_EN
                  par_err <= (^shift_reg) ^ par_bit;
`endif
                  state   <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt - 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and randomized frames against a frame-level
// expectation queue; each rdy rising edge is matched to the next expected byte.

module tb_uart_rx_core;

   localparam int unsigned BAUD = 16;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned PAR = 1;
`else
   localparam int unsigned PAR = 0;
`endif
   localparam int unsigned NBITS = 10 + PAR;
   localparam int unsigned FRAME = NBITS * BAUD;
   // Start edge to rdy: 9.5 bit periods (+1 with parity) plus sync/arm delay
   localparam int unsigned LAT   = (19 * BAUD) / 2 + 3 + PAR * BAUD;

   typedef struct packed {
      logic [7:0] d;
      logic       fe;
      logic       pe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       RX = 1'b1;
   logic       clr_rdy = 1'b0;
   logic [7:0] rx_data;
   logic       rdy;
   logic       frm_err;
   logic       par_err;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   lat_n;
   exp_t exp_q[$];
   exp_t mon_e;
   logic rdy_q = 1'b0;

   always #5 clk = ~clk;

   uart_rx_core #(.BAUD_DIV(BAUD)) dut (
      .clk     (clk),
      .rst     (rst),
      .RX      (RX),
      .clr_rdy (clr_rdy),
      .rx_data (rx_data),
      .rdy     (rdy),
      .frm_err (frm_err),
      .par_err (par_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
   endtask

   // Advance n rising edges and settle 1 time unit past the last one
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one frame; flip inverts the even-parity bit; gap = idle clocks after
   task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic flip,
                             input int gap, input bit expect_done);
      logic [10:0] bits;
      exp_t        e;
      bits       = 11'h7FF;
      bits[0]    = 1'b0;
      bits[8:1]  = d;
      if (PAR != 0) begin
         bits[9]  = (^d) ^ flip;
         bits[10] = stop_v;
      end else begin
         bits[9]  = stop_v;
      end
      if (expect_done) begin
         e.d  = d;
         e.fe = ~stop_v;
         e.pe = (PAR != 0) ? flip : 1'b0;
         exp_q.push_back(e);
      end
      for (int i = 0; i < int'(NBITS); i++) begin
         RX = bits[i];
         tick(BAUD);
      end
      RX = 1'b1;
      if (gap > 0) tick(gap);
   endtask

   // Scoreboard: every new byte must match the oldest outstanding frame
   always @(negedge clk) begin
      if (!rst && rdy && !rdy_q) begin
         if (exp_q.size() == 0) begin
            check("spurious_rdy", 32'(rdy), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("sb_rx_data", 32'(rx_data), 32'(mon_e.d));
            check("sb_frm_err", 32'(frm_err), 32'(mon_e.fe));
            check("sb_par_err", 32'(par_err), 32'(mon_e.pe));
         end
      end
      rdy_q = rdy;
   end

   initial begin
      logic [7:0] rd;
      logic       rs;
      logic       rf;
      int         rg;

      tick(2);
      rst = 1'b0;
      check("rst_rdy", 32'(rdy), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'h00);
      check("rst_frm_err", 32'(frm_err), 32'd0);
      check("rst_par_err", 32'(par_err), 32'd0);
      tick(4);

      // Single frame with latency measurement
      fork
         send_frame(8'hA5, 1'b1, 1'b0, 4, 1'b1);
         begin
            lat_n = 0;
            while (!rdy && lat_n < 400) begin
               tick(1);
               lat_n++;
            end
            check("latency_ok", 32'(lat_n >= int'(LAT) - 2 && lat_n <= int'(LAT) + 2), 32'd1);
            check("a5_data", 32'(rx_data), 32'hA5);
         end
      join

      // Back-to-back frames
      fork
         begin
            send_frame(8'hCD, 1'b1, 1'b0, 0, 1'b1);
            send_frame(8'hAB, 1'b1, 1'b0, 4, 1'b1);
         end
         begin
            tick(FRAME);
            check("b2b_first_rdy", 32'(rdy), 32'd1);
            check("b2b_first_data", 32'(rx_data), 32'hCD);
            tick(3);
            check("b2b_rdy_clr", 32'(rdy), 32'd0);
            tick(LAT - 10);
            check("b2b_hold_data", 32'(rx_data), 32'hCD);
            check("b2b_hold_rdy", 32'(rdy), 32'd0);
            tick(12);
            check("b2b_second_rdy", 32'(rdy), 32'd1);
            check("b2b_second_data", 32'(rx_data), 32'hAB);
         end
      join

      // clr_rdy knock-down, then clr_rdy on the exact set cycle
      send_frame(8'h5A, 1'b1, 1'b0, 4, 1'b1);
      clr_rdy = 1'b1;
      tick(1);
      clr_rdy = 1'b0;
      check("clr_rdy", 32'(rdy), 32'd0);
      check("clr_keep_data", 32'(rx_data), 32'h5A);
      fork
         send_frame(8'h69, 1'b1, 1'b0, 4, 1'b1);
         begin
            tick(LAT - 1);
            clr_rdy = 1'b1;
            tick(1);
            clr_rdy = 1'b0;
            check("clr_same_cycle", 32'(rdy), 32'd1);
         end
      join

      // Start-bit glitch must not produce a byte
      RX = 1'b0;
      tick(4);
      RX = 1'b1;
      tick(40);
      check("glitch_no_rdy", 32'(rdy), 32'd0);
      send_frame(8'h3C, 1'b1, 1'b0, 4, 1'b1);
      check("after_glitch_data", 32'(rx_data), 32'h3C);

      // Framing error, then a clean frame clears it
      send_frame(8'hFF, 1'b0, 1'b0, 6, 1'b1);
      check("frm_err_set", 32'(frm_err), 32'd1);
      send_frame(8'h00, 1'b1, 1'b0, 4, 1'b1);
      check("frm_err_clear", 32'(frm_err), 32'd0);

      // Reset partway through a frame aborts it
      fork
         send_frame(8'hF0, 1'b1, 1'b0, 4, 1'b0);
         begin
            tick(5 * BAUD);
            rst = 1'b1;
            tick(1);
            rst = 1'b0;
            check("midrst_rdy", 32'(rdy), 32'd0);
            check("midrst_data", 32'(rx_data), 32'h00);
         end
      join
      tick(40);
      check("abort_no_rdy", 32'(rdy), 32'd0);
      send_frame(8'h12, 1'b1, 1'b0, 4, 1'b1);
      check("after_rst_data", 32'(rx_data), 32'h12);

      // Parity: bad then good even parity on 0x07
      send_frame(8'h07, 1'b1, 1'b1, 4, 1'b1);
      send_frame(8'h07, 1'b1, 1'b0, 4, 1'b1);

      // Randomized frames
      for (int k = 0; k < 16; k++) begin
         rd = 8'($urandom);
         rs = ($urandom_range(0, 7) != 0);
         rf = 1'($urandom_range(0, 1));
         rg = rs ? int'($urandom_range(0, 8)) : int'($urandom_range(4, 10));
         send_frame(rd, rs, rf, rg, 1'b1);
      end

      tick(LAT);
      check("all_frames_seen", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
Byte-level UART receiver, 8N1, LSB first, idle-high line. It is the receive end of the serial link whose transmit end is the UART transmitter inside the remote command sender. The command wrapper instantiates it to recover bytes, then assembles them into 16-bit commands. It presents one byte at a time with a level `rdy` flag and a `clr_rdy` knock-down.

Parameters:
- BAUD_DIV, 2604, clocks per bit period (50 MHz / 19200 baud); legal range >= 4; the bench uses 16.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- RX  input  1  serial line, asynchronous to clk, idle high.
- clr_rdy  input  1  single-cycle pulse; clears rdy.
- rx_data  output  8  last completed byte; held until the next frame completes.
- rdy  output  1  a byte is available in rx_data.
- frm_err  output  1  stop bit of the last frame sampled low.
- par_err  output  1  parity mismatch on the last frame (see Optional Feature).

Behaviour:
- Synchronizer:
  - RX passes through two flops, both preset to 1 on rst.
  - A third flop (rx_prev) holds the previous synced value for edge detection.
- Reset values: rdy=0, rx_data=8'h00, frm_err=0, par_err=0, state=IDLE, counters=0, shift register=0, sync flops=1.
- Reset mid-frame aborts the frame immediately. No rdy is produced from that partial frame.
- Counters:
  - baud_cnt is $clog2(BAUD_DIV+1) bits wide and counts down; the sample event is baud_cnt==0.
  - bit_cnt is 4 bits.
- State machine (IDLE, START, DATA, STOP; PARITY only when the optional feature is enabled):
  - IDLE: a falling edge on the synced RX (synced==0 && rx_prev==1) moves to START, loads baud_cnt=BAUD_DIV/2-1 and clears rdy. A low level without an edge does not arm the receiver, so after rst a stuck-low or mid-frame line is ignored until it returns high.
  - START: at the sample event, if synced RX==0, go to DATA with baud_cnt=BAUD_DIV-1 and bit_cnt=0. Otherwise it was a glitch: return to IDLE with no output change (rdy stays cleared).
  - DATA: at each sample event, shift synced RX into the MSB of the shift register (LSB-first framing), increment bit_cnt and reload baud_cnt=BAUD_DIV-1. After the 8th sample go to STOP.
  - STOP: at the sample event:
    - rx_data <= shift register;
    - rdy <= 1;
    - frm_err <= ~synced RX;
    - go to IDLE.
  - The receiver returns to IDLE at mid-stop-bit, so a start bit immediately following the stop bit is caught.
- rdy rules:
  - set at the STOP sample;
  - cleared by clr_rdy, or by the start edge of the next frame;
  - set wins over clr_rdy in the same cycle;
  - a new frame does not disturb rx_data or the error flags until its own STOP sample.
- Latency: rdy rises 9.5*BAUD_DIV + 3 clocks (±1) after the RX pin falls for the start bit.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame is 8E1: a PARITY state sits between DATA and STOP and samples one extra bit one period after bit 7.
  - par_err <= (XOR of the 8 data bits) ^ parity bit; it is updated at the STOP sample together with rdy.
  - rdy latency grows by BAUD_DIV.
- Undefined: 8N1 framing, no PARITY state, par_err tied to 0.

Test Plan:
- BAUD_DIV=16; rst high 2 cycles; send 0xA5 -> rdy=1 at 155±2 clocks after the start edge, rx_data=8'hA5, frm_err=0, par_err=0.
- Send 0xCD then 0xAB back-to-back (second start bit right after the first stop bit) -> rdy falls within 3 clocks of the second start edge; rx_data stays 8'hCD until the second rdy, then becomes 8'hAB.
- After a 0x5A frame, pulse clr_rdy for 1 cycle -> rdy=0 on the next posedge, rx_data still 8'h5A; a clr_rdy pulse on the exact rdy-set cycle leaves rdy=1.
- RX low for 4 clocks, then high -> no rdy and state back in IDLE; then send 0x3C -> rx_data=8'h3C, rdy=1.
- Send 0xFF with the stop bit driven low -> rdy=1, rx_data=8'hFF, frm_err=1. Next clean 0x00 frame -> frm_err=0.
- Start 0xF0; assert rst for 1 cycle after the bit-3 sample -> rdy=0, rx_data=8'h00 next cycle; no rdy from the remainder of the frame; then send 0x12 -> rx_data=8'h12, rdy=1.
- With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> par_err=1; repeat with parity bit 1 -> par_err=0.
